serial_word_rx: RTL and testbench

Streaming receiver for the `serial_en` / `serial_out` link driven by `serializer`. It self-times on the rising edge of `serial_en` and samples each bit at mid-period using the programmed clock divider. Received bits are assembled LSB-first into words and delivered one word at a time over a valid/ready handshake, for example into a FIFO. Unlike `deserializer`, it needs no `start` strobe and no frame depth: the frame ends when `serial_en` drops.

---
 rtl/serial_word_rx.sv | 142 ++++++++++++++
 tb/tb_serial_word_rx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_rx.sv
// Self-timed serial word receiver: frames open on a rising serial_en, bits are sampled
// mid-period and packed LSB-first into words offered on a valid/ready output slot.
module serial_word_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          serial_in,
    input  logic                          serial_en,
    input  logic [DIV_WIDTH-1:0]          clk_div,
    input  logic [$clog2(DATA_WIDTH):0]   width,
    output logic [DATA_WIDTH-1:0]         word_data,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic                          frame_done,
    output logic [CNT_WIDTH-1:0]          word_count,
    output logic                          overrun,
    output logic                          err_partial
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic IDLE = 1'b0;
    localparam logic RECV = 1'b1;

    // Output handshake: a word moves on every cycle where word_valid & word_ready are
    // both high; word_data is held while word_valid & ~word_ready.
    logic                  state;
    logic                  serial_en_d;
    logic [DIV_WIDTH-1:0]  clk_div_r;
    logic [BW-1:0]         width_r;
    logic [DIV_WIDTH-1:0]  clk_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_r;

    logic                  en_rise;
    logic                  start;
    logic                  in_recv;
    logic [BW-1:0]         width_clamped;
    logic [DIV_WIDTH-1:0]  cur_div;
    logic [DIV_WIDTH-1:0]  cur_cnt;
    logic [BW-1:0]         cur_width;
    logic [BW-1:0]         cur_bit;
    logic [DATA_WIDTH-1:0] cur_shift;
    logic [CNT_WIDTH-1:0]  cur_wc;
    logic [DATA_WIDTH-1:0] assembled;
    logic                  sample;
    logic                  got_bit;
    logic                  word_done;
    logic                  frame_end;
    logic                  slot_free;

    // The en_rise cycle is already clk_cnt=0 of bit 0, so with clk_div<=1 the first
    // sample falls in that cycle; the cur_* views use the live inputs there.
    always_comb begin
        en_rise       = serial_en & ~serial_en_d;
        start         = (state == IDLE) & enable & en_rise;
        in_recv       = (state == RECV) & enable;
        width_clamped = (width > (BW+1)'(DATA_WIDTH - 1)) ? BW'(DATA_WIDTH - 1) : width[BW-1:0];
        cur_div       = start ? clk_div : clk_div_r;
        cur_cnt       = start ? '0 : clk_cnt;
        cur_width     = start ? width_clamped : width_r;
        cur_bit       = start ? '0 : bit_cnt;
        cur_shift     = start ? '0 : shift_r;
        cur_wc        = start ? '0 : word_count;
        sample        = (start | in_recv) & (cur_cnt == (cur_div >> 1));
        got_bit       = sample & serial_en;
        word_done     = got_bit & (cur_bit == cur_width);
        frame_end     = in_recv & sample & ~serial_en;
        slot_free     = ~word_valid | word_ready;
        assembled          = cur_shift;
        assembled[cur_bit] = serial_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            serial_en_d <= 1'b0;
            clk_div_r   <= '0;
            width_r     <= '0;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shift_r     <= '0;
            word_data   <= '0;
            word_valid  <= 1'b0;
            frame_done  <= 1'b0;
            word_count  <= '0;
            overrun     <= 1'b0;
            err_partial <= 1'b0;
        end else begin
            serial_en_d <= serial_en;
            frame_done  <= frame_end;

            if (start) begin
                state       <= RECV;
                clk_div_r   <= clk_div;
                width_r     <= width_clamped;
                bit_cnt     <= '0;
                shift_r     <= '0;
                word_count  <= '0;
                overrun     <= 1'b0;
                err_partial <= 1'b0;
            end

            if (start | in_recv)
                clk_cnt <= (cur_cnt == cur_div) ? '0 : cur_cnt + 1'b1;

            if (got_bit) begin
                if (word_done) begin
                    bit_cnt    <= '0;
                    shift_r    <= '0;
                    word_count <= (&cur_wc) ? cur_wc : cur_wc + 1'b1;
                end else begin
                    bit_cnt <= cur_bit + 1'b1;
                    shift_r <= assembled;
                end
            end

            if (frame_end) begin
                state <= IDLE;
                if (bit_cnt != '0)
                    err_partial <= 1'b1;
            end

            // Dropping enable abandons the frame silently; flags stay as they are.
            if ((state == RECV) && !enable)
                state <= IDLE;

            if (word_done && slot_free) begin
                word_data  <= assembled;
                word_valid <= 1'b1;
            end else if (word_done) begin
                overrun <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: drives serializer-style frames and compares delivered words
// and status outputs against a word-level model of the link.
module tb_serial_word_rx;

    localparam int DW   = 32;
    localparam int DIVW = 8;
    localparam int CW   = 8;
    localparam int WW   = $clog2(DW) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic            serial_in;
    logic            serial_en;
    logic [DIVW-1:0] clk_div;
    logic [WW-1:0]   width;
    logic [DW-1:0]   word_data;
    logic            word_valid;
    logic            word_ready;
    logic            frame_done;
    logic [CW-1:0]   word_count;
    logic            overrun;
    logic            err_partial;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    bit tx_bits[$];

    serial_word_rx #(.DATA_WIDTH(DW), .DIV_WIDTH(DIVW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .serial_in(serial_in), .serial_en(serial_en),
        .clk_div(clk_div), .width(width), .word_data(word_data), .word_valid(word_valid),
        .word_ready(word_ready), .frame_done(frame_done), .word_count(word_count),
        .overrun(overrun), .err_partial(err_partial)
    );

    always #5 clk = ~clk;

    // Consumer side: record every accepted word and every frame_done cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid && word_ready) got_q.push_back(word_data);
            if (frame_done) fd_cnt++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_sb();
        got_q.delete();
        exp_q.delete();
        fd_cnt = 0;
    endtask

    // Model: a word of nbits bits arrives as its low nbits bits, zero above.
    task automatic queue_word(input logic [DW-1:0] value, input int nbits);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < nbits; i++) begin
            tx_bits.push_back(value[i]);
            m[i] = 1'b1;
        end
        exp_q.push_back(value & m);
    endtask

    task automatic send_frame(input int div);
        clk_div = DIVW'(div);
        foreach (tx_bits[k]) begin
            repeat (div + 1) begin
                serial_en = 1'b1;
                serial_in = tx_bits[k];
                tick();
            end
        end
        serial_en = 1'b0;
        serial_in = 1'b0;
        tick(div + 4);
        tx_bits.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        checks += 6;
        if (word_data !== '0) begin errors++; $display("FAIL reset_word_data: got %h expected 0", word_data); end
        if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid: got %b expected 0", word_valid); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        if (word_count !== '0) begin errors++; $display("FAIL reset_word_count: got %0d expected 0", word_count); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        if (err_partial !== 1'b0) begin errors++; $display("FAIL reset_err_partial: got %b expected 0", err_partial); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        clear_sb();
        width = 7;
        queue_word(32'hA5, 8);
        queue_word(32'h3C, 8);
        send_frame(3);
        checks++;
        if (got_q.size() !== 2) begin errors++; $display("FAIL basic_count: got %0d words expected 2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        checks += 4;
        if (fd_cnt !== 1) begin errors++; $display("FAIL basic_frame_done: got %0d cycles expected 1", fd_cnt); end
        if (word_count !== 2) begin errors++; $display("FAIL basic_word_count: got %0d expected 2", word_count); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b expected 0", overrun); end
        if (err_partial !== 1'b0) begin errors++; $display("FAIL basic_err_partial: got %b expected 0", err_partial); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            int div, w, eff, nw;
            clear_sb();
            div = $urandom_range(0, 5);
            w   = $urandom_range(0, 40);
            eff = ((w > DW - 1) ? DW - 1 : w) + 1;
            nw  = $urandom_range(1, 4);
            width = WW'(w);
            for (int j = 0; j < nw; j++) queue_word($urandom, eff);
            send_frame(div);
            checks++;
            if (got_q.size() !== exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d words expected %0d (div=%0d width=%0d)", f, got_q.size(), exp_q.size(), div, w);
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_word%0d: got %h expected %h", f, i, got_q[i], exp_q[i]); end
            end
            checks += 3;
            if (fd_cnt !== 1) begin errors++; $display("FAIL rand%0d_frame_done: got %0d expected 1", f, fd_cnt); end
            if (word_count !== CW'(nw)) begin errors++; $display("FAIL rand%0d_word_count: got %0d expected %0d", f, word_count, nw); end
            if ({overrun, err_partial} !== 2'b00) begin errors++; $display("FAIL rand%0d_flags: got %b expected 00", f, {overrun, err_partial}); end
        end
    endtask

    task automatic test_backpressure();
        clear_sb();
        word_ready = 1'b0;
        width = 3;
        queue_word(32'h1, 4);
        queue_word(32'h2, 4);
        queue_word(32'h3, 4);
        send_frame(0);
        checks += 5;
        if (word_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", word_valid); end
        if (word_data !== 32'h1) begin errors++; $display("FAIL bp_data: got %h expected 00000001", word_data); end
        if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b expected 1", overrun); end
        if (word_count !== 3) begin errors++; $display("FAIL bp_word_count: got %0d expected 3", word_count); end
        if (got_q.size() !== 0) begin errors++; $display("FAIL bp_no_transfer: got %0d words expected 0", got_q.size()); end
        word_ready = 1'b1;
        tick();
        checks++;
        if (word_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b expected 0", word_valid); end
        tick(2);
        checks += 2;
        if (got_q.size() !== 1) begin errors++; $display("FAIL bp_transfers: got %0d expected 1", got_q.size()); end
        if (got_q.size() > 0 && got_q[0] !== 32'h1) begin errors++; $display("FAIL bp_xfer_data: got %h expected 00000001", got_q[0]); end
    endtask

    task automatic test_simultaneous();
        clear_sb();
        word_ready = 1'b0;
        width = 0;
        clk_div = 0;
        serial_en = 1'b1; serial_in = 1'b0; tick();
        serial_in = 1'b1; word_ready = 1'b1; tick();
        serial_en = 1'b0; serial_in = 1'b0; word_ready = 1'b0; tick(3);
        checks += 5;
        if (word_valid !== 1'b1) begin errors++; $display("FAIL sim_valid: got %b expected 1", word_valid); end
        if (word_data !== 32'h1) begin errors++; $display("FAIL sim_data: got %h expected 00000001", word_data); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL sim_overrun: got %b expected 0", overrun); end
        if (word_count !== 2) begin errors++; $display("FAIL sim_word_count: got %0d expected 2", word_count); end
        if (got_q.size() !== 1 || got_q[0] !== 32'h0) begin errors++; $display("FAIL sim_transfer: got %0d words expected 1 word of 0", got_q.size()); end
        word_ready = 1'b1;
        tick(2);
    endtask

    task automatic test_partial();
        clear_sb();
        width = 7;
        for (int i = 0; i < 5; i++) tx_bits.push_back(1'($urandom));
        send_frame(2);
        checks += 5;
        if (got_q.size() !== 0 || word_valid !== 1'b0) begin errors++; $display("FAIL partial_words: got %0d words valid=%b expected none", got_q.size(), word_valid); end
        if (fd_cnt !== 1) begin errors++; $display("FAIL partial_frame_done: got %0d expected 1", fd_cnt); end
        if (err_partial !== 1'b1) begin errors++; $display("FAIL partial_err: got %b expected 1", err_partial); end
        if (word_count !== 0) begin errors++; $display("FAIL partial_word_count: got %0d expected 0", word_count); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL partial_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_abort();
        logic [DW-1:0] v;
        clear_sb();
        width = 7;
        clk_div = 3;
        serial_en = 1'b1; serial_in = 1'b1;
        tick(10);
        enable = 1'b0;
        tick(3);
        checks += 2;
        if (fd_cnt !== 0) begin errors++; $display("FAIL abort_frame_done: got %0d expected 0", fd_cnt); end
        if (word_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", word_valid); end
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            serial_in = 1'($urandom);
            tick();
        end
        checks += 2;
        if (got_q.size() !== 0 || word_valid !== 1'b0) begin errors++; $display("FAIL abort_no_capture: got %0d words valid=%b expected none", got_q.size(), word_valid); end
        if (fd_cnt !== 0) begin errors++; $display("FAIL abort_no_frame: got %0d expected 0", fd_cnt); end
        serial_en = 1'b0; serial_in = 1'b0;
        tick(5);
        v = $urandom;
        queue_word(v, 8);
        send_frame(3);
        checks += 2;
        if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL abort_fresh_word: got %0d words expected 1 of %h", got_q.size(), exp_q[0]); end
        if (fd_cnt !== 1) begin errors++; $display("FAIL abort_fresh_frame_done: got %0d expected 1", fd_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] nib;
        clear_sb();
        word_ready = 1'b0;
        width = 3;
        clk_div = 1;
        nib = 4'hB;
        for (int k = 0; k < 6; k++) begin
            repeat (2) begin
                serial_en = 1'b1;
                serial_in = (k < 4) ? nib[k] : 1'b1;
                tick();
            end
        end
        checks++;
        if (word_valid !== 1'b1 || word_data !== 32'hB) begin errors++; $display("FAIL midrst_pre: got valid=%b data=%h expected 1 0000000b", word_valid, word_data); end
        rst = 1'b1;
        tick();
        checks += 3;
        if (word_data !== '0 || word_valid !== 1'b0) begin errors++; $display("FAIL midrst_word: got valid=%b data=%h expected 0", word_valid, word_data); end
        if (word_count !== '0 || frame_done !== 1'b0) begin errors++; $display("FAIL midrst_count: got count=%0d fd=%b expected 0", word_count, frame_done); end
        if (overrun !== 1'b0 || err_partial !== 1'b0) begin errors++; $display("FAIL midrst_flags: got %b%b expected 00", overrun, err_partial); end
        rst = 1'b0;
        serial_en = 1'b0; serial_in = 1'b0;
        tick(4);
        checks++;
        if (word_valid !== 1'b0 || fd_cnt !== 0) begin errors++; $display("FAIL midrst_idle: got valid=%b fd=%0d expected 0", word_valid, fd_cnt); end
        word_ready = 1'b1;
    endtask

    task automatic test_clamp();
        clear_sb();
        width = 63;
        queue_word($urandom, DW);
        queue_word($urandom, DW);
        send_frame(0);
        checks++;
        if (got_q.size() !== 2) begin errors++; $display("FAIL clamp_count: got %0d words expected 2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL clamp_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        checks += 2;
        if (word_count !== 2) begin errors++; $display("FAIL clamp_word_count: got %0d expected 2", word_count); end
        if (err_partial !== 1'b0) begin errors++; $display("FAIL clamp_err_partial: got %b expected 0", err_partial); end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; serial_in = 1'b0; serial_en = 1'b0;
        word_ready = 1'b0; clk_div = '0; width = '0;
        test_reset();
        enable = 1'b1;
        word_ready = 1'b1;
        test_basic();
        test_random();
        test_backpressure();
        test_simultaneous();
        test_partial();
        test_abort();
        test_reset_mid();
        test_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
